// File: rtl/rgb565_pkg.sv
// Shared types and byte-lane layout for the RGB565 quad path and the grayscale instruction.
package rgb565_pkg;
  localparam int PIXEL_W         = 16;
  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXELS_PER_QUAD = 4;
  localparam int QUAD_W          = PIXEL_W * PIXELS_PER_QUAD;

  // Bit positions of the two byte lanes inside one 16-bit pixel.
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 8;

  typedef struct packed {
    logic        first;
    logic [31:0] b;
    logic [31:0] a;
  } quad_t;

  // Bit offset of stream byte k inside the 64-bit {quadB, quadA} image.
  function automatic logic [5:0] byte_offset(input logic [2:0] k, input logic hbf);
    logic hi;
    hi = (k[0] == 1'b0) ? hbf : !hbf;
    return {k[2:1], hi, 3'b000};
  endfunction
endpackage

// File: rtl/rgb565_quad_collector_if.sv
// Byte-stream input, quad output handshake and status of the quad collector.
interface rgb565_quad_collector_if #(parameter int FIFO_DEPTH = 4);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          byteValid;
  logic [7:0]    byteData;
  logic          frameStart;
  logic          quadReady;
  logic          quadValid;
  logic [31:0]   quadA;
  logic [31:0]   quadB;
  logic          quadFirst;
  logic          clearOverflow;
  logic          overflow;
  logic [LW-1:0] fillLevel;

  modport master (
    output byteValid, byteData, frameStart, quadReady, clearOverflow,
    input  quadValid, quadA, quadB, quadFirst, overflow, fillLevel
  );

  modport slave (
    input  byteValid, byteData, frameStart, quadReady, clearOverflow,
    output quadValid, quadA, quadB, quadFirst, overflow, fillLevel
  );
endinterface

// File: rtl/quad_sync_fifo.sv
// Single-clock FIFO of quad entries; full/empty come from the occupancy count.
module quad_sync_fifo
  import rgb565_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  quad_t                  wdata,
  output quad_t                  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  quad_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot being written, so full does not block.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/rgb565_quad_collector.sv
// Assembles 8 camera bytes into a 4-pixel RGB565 quad and queues it for the grayscale instruction.
module rgb565_quad_collector
  import rgb565_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int HIGH_BYTE_FIRST = 1
) (
  input logic                   clock,
  input logic                   reset,
  rgb565_quad_collector_if.slave bus
);
  localparam logic HBF = (HIGH_BYTE_FIRST != 0);

  logic [2:0]        byte_cnt;
  logic [QUAD_W-1:0] asm_q, asm_next;
  logic [5:0]        off;
  logic              first_pending;
  logic              ovf;
  logic              done, pop_req, accepted, drop;
  logic              full, empty;
  quad_t             wq, head;

  always_comb begin
    off      = byte_offset(bus.frameStart ? 3'd0 : byte_cnt, HBF);
    asm_next = asm_q;
    asm_next[off +: 8] = bus.byteData;
  end

  // A frameStart byte is byte 0 of the new frame, so it can never complete the old quad.
  assign done     = bus.byteValid && !bus.frameStart && (byte_cnt == 3'd7);
  assign pop_req  = bus.quadReady && !empty;
  assign accepted = done && (!full || pop_req);
  assign drop     = done && full && !pop_req;
  assign wq       = '{first: first_pending, b: asm_next[63:32], a: asm_next[31:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt      <= '0;
      asm_q         <= '0;
      first_pending <= 1'b1;
      ovf           <= 1'b0;
    end else begin
      if (bus.byteValid) asm_q <= asm_next;
      if (bus.frameStart) begin
        byte_cnt      <= bus.byteValid ? 3'd1 : 3'd0;
        first_pending <= 1'b1;
      end else begin
        if (bus.byteValid) byte_cnt <= byte_cnt + 3'd1;
        if (accepted)      first_pending <= 1'b0;
      end
      if (drop)                   ovf <= 1'b1;
      else if (bus.clearOverflow) ovf <= 1'b0;
    end
  end

  quad_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (done),
    .pop   (bus.quadReady),
    .wdata (wq),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (bus.fillLevel)
  );

  assign bus.quadValid = !empty;
  assign bus.quadA     = head.a;
  assign bus.quadB     = head.b;
  assign bus.quadFirst = head.first;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_rgb565_quad_collector.sv
// Directed bench: byte-level model of the collector checked every cycle, plus literal expectations.
module tb_rgb565_quad_collector;
  localparam int DEPTH = 4;
  localparam int HBF   = 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rgb565_quad_collector_if #(.FIFO_DEPTH(DEPTH)) bus ();

  rgb565_quad_collector #(.FIFO_DEPTH(DEPTH), .HIGH_BYTE_FIRST(HBF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscomp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the current frame position, queue of finished quads.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        first;
  } mq_t;

  mq_t        mq[$];
  logic [7:0] mbuf[8];
  int         mcnt;
  bit         mfirst, movf, armed = 0;

  function automatic logic [15:0] pix(input int p);
    return (HBF != 0) ? {mbuf[2*p], mbuf[2*p+1]} : {mbuf[2*p+1], mbuf[2*p]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      mcnt = 0; mfirst = 1; movf = 0; armed = 1;
    end else if (armed) begin
      bit  pop, fin, drop;
      mq_t nq;
      pop  = (mq.size() != 0) && bus.quadReady;
      fin  = 0;
      drop = 0;
      if (bus.frameStart) begin
        mcnt = 0; mfirst = 1;
        if (bus.byteValid) begin mbuf[0] = bus.byteData; mcnt = 1; end
      end else if (bus.byteValid) begin
        mbuf[mcnt] = bus.byteData;
        mcnt++;
        if (mcnt == 8) begin
          mcnt = 0; fin = 1;
          nq.a = {pix(1), pix(0)};
          nq.b = {pix(3), pix(2)};
          nq.first = mfirst;
        end
      end
      if (pop) void'(mq.pop_front());
      if (fin) begin
        if (mq.size() < DEPTH) begin mq.push_back(nq); mfirst = 0; end
        else drop = 1;
      end
      if (drop) movf = 1;
      else if (bus.clearOverflow) movf = 0;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("quadValid", 64'(bus.quadValid), 64'(mq.size() != 0));
      chk("fillLevel", 64'(bus.fillLevel), 64'(mq.size()));
      chk("overflow",  64'(bus.overflow),  64'(movf));
      if (mq.size() != 0) begin
        chk("quadA",     64'(bus.quadA),     64'(mq[0].a));
        chk("quadB",     64'(bus.quadB),     64'(mq[0].b));
        chk("quadFirst", 64'(bus.quadFirst), 64'(mq[0].first));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    bus.byteValid = 0; bus.frameStart = 0; bus.clearOverflow = 0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic fs);
    bus.byteValid = 1; bus.byteData = b; bus.frameStart = fs;
    tick();
    bus.byteValid = 0; bus.frameStart = 0;
  endtask

  task automatic send_quad(input logic [7:0] base);
    for (int k = 0; k < 8; k++) send(base + 8'(k), 1'b0);
  endtask

  logic [7:0] v1 [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
  logic [7:0] v2 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  initial begin
    reset = 1; bus.quadReady = 0; bus.byteData = 0;
    bus.byteValid = 0; bus.frameStart = 0; bus.clearOverflow = 0;
    repeat (2) tick();
    chk("rst quadValid", 64'(bus.quadValid), 64'd0);
    chk("rst quadA",     64'(bus.quadA),     64'd0);
    chk("rst quadB",     64'(bus.quadB),     64'd0);
    chk("rst quadFirst", 64'(bus.quadFirst), 64'd0);
    reset = 0;

    // First quad of a frame
    bus.frameStart = 1; tick(); bus.frameStart = 0;
    for (int k = 0; k < 8; k++) send(v1[k], 1'b0);
    chk("q1 valid", 64'(bus.quadValid), 64'd1);
    chk("q1 A",     64'(bus.quadA),     64'h07E0F800);
    chk("q1 B",     64'(bus.quadB),     64'hFFFF001F);
    chk("q1 first", 64'(bus.quadFirst), 64'd1);

    // Second quad with the consumer ready
    bus.quadReady = 1;
    for (int k = 0; k < 8; k++) send(v2[k], 1'b0);
    chk("q2 A",     64'(bus.quadA),     64'h56781234);
    chk("q2 B",     64'(bus.quadB),     64'hDEF09ABC);
    chk("q2 first", 64'(bus.quadFirst), 64'd0);
    tick();
    chk("q2 drained", 64'(bus.fillLevel), 64'd0);
    bus.quadReady = 0;

    // Overflow with five quads into four slots
    for (int q = 0; q < 4; q++) send_quad(8'(q * 16));
    chk("full level", 64'(bus.fillLevel), 64'd4);
    chk("no ovf yet", 64'(bus.overflow),  64'd0);
    send_quad(8'h80);
    chk("ovf set",    64'(bus.overflow),  64'd1);
    chk("full level2", 64'(bus.fillLevel), 64'd4);
    bus.quadReady = 1; idle(4); bus.quadReady = 0;
    chk("drained", 64'(bus.fillLevel), 64'd0);
    bus.clearOverflow = 1; tick(); bus.clearOverflow = 0;
    chk("ovf clr", 64'(bus.overflow), 64'd0);

    // frameStart with a byte mid-quad
    for (int k = 1; k <= 5; k++) send(8'(k), 1'b0);
    send(8'hAA, 1'b1);
    for (int k = 1; k <= 7; k++) send(8'hB0 + 8'(k), 1'b0);
    chk("fs level",  64'(bus.fillLevel),   64'd1);
    chk("fs hi AA",  64'(bus.quadA[15:8]), 64'hAA);
    chk("fs A",      64'(bus.quadA),       64'hB2B3AAB1);
    chk("fs first",  64'(bus.quadFirst),   64'd1);
    bus.quadReady = 1; idle(1); bus.quadReady = 0;

    // Full FIFO, pop on the completing cycle
    for (int q = 0; q < 4; q++) send_quad(8'h40 + 8'(q * 8));
    for (int k = 0; k < 7; k++) send(8'hC0 + 8'(k), 1'b0);
    bus.quadReady = 1; send(8'hC7, 1'b0); bus.quadReady = 0;
    chk("swap level", 64'(bus.fillLevel), 64'd4);
    chk("swap ovf",   64'(bus.overflow),  64'd0);
    bus.quadReady = 1; idle(4); bus.quadReady = 0;

    // Reset mid-quad with two entries stored
    send_quad(8'h10); send_quad(8'h20);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    reset = 1; tick(); reset = 0;
    chk("mrst valid", 64'(bus.quadValid), 64'd0);
    chk("mrst level", 64'(bus.fillLevel), 64'd0);
    chk("mrst A",     64'(bus.quadA),     64'd0);
    send_quad(8'h60);
    chk("post first", 64'(bus.quadFirst), 64'd1);
    chk("post A",     64'(bus.quadA),     64'h62636061);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end
endmodule

// File: doc/rgb565_quad_collector.md
Name: rgb565_quad_collector

Overview:
- Upstream feeder of the packed RGB565-to-grayscale custom instruction.
- Takes the camera byte stream, 8 bits per beat, two beats per RGB565 pixel.
- Assembles 4 pixels into the two 32-bit operand words that instruction consumes, and buffers them in a small FIFO.
- Software or the DMA side pops one quad per conversion through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4: number of quad entries buffered; power of two, minimum 2.
- HIGH_BYTE_FIRST, 1: 1 means the first byte of a pixel is bits [15:8]; 0 means it is bits [7:0].

Ports:
- clock, in, 1: system clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- byteValid, in, 1: byteData is valid this cycle.
- byteData, in, 8: camera pixel byte.
- frameStart, in, 1: one-cycle pulse at the start of each frame.
- quadReady, in, 1: the consumer accepts the head entry.
- quadValid, out, 1: the FIFO is not empty.
- quadA, out, 32: pixel0 in [15:0], pixel1 in [31:16].
- quadB, out, 32: pixel2 in [15:0], pixel3 in [31:16].
- quadFirst, out, 1: the head quad is the first quad of its frame.
- clearOverflow, in, 1: clears the overflow flag.
- overflow, out, 1: sticky flag; a completed quad was dropped.
- fillLevel, out, $clog2(FIFO_DEPTH)+1: number of occupied entries.

Behaviour:
- Reset values: quadValid=0, quadA=0, quadB=0, quadFirst=0, overflow=0, fillLevel=0.
- On reset: byte index and pixel index go to 0, the first-pending flag is set, and FIFO pointers go to 0.
- Assembly uses a 3-bit byte counter (0..7).
  - Byte k lands in pixel k>>1.
  - Even k is the high half when HIGH_BYTE_FIRST=1.
  - The counter advances only on byteValid.
- The quad completes on the cycle byte 7 is accepted; the counter wraps to 0.
- Write is registered: the entry is in the FIFO on the next edge, so quadValid rises 1 cycle after byte 7.
  - Total latency from byte 7 to quadValid is 1 cycle when the FIFO was empty.
- FIFO entry contents: {first flag, quadB, quadA}.
  - The first flag is the first-pending flag at the moment of completion.
  - The first-pending flag clears on a successful push.
- Outputs quadA, quadB and quadFirst show the head entry combinationally from the FIFO registers.
  - They hold stable while quadValid=1 and quadReady=0.
- Pop happens when quadValid && quadReady. quadReady while empty has no effect.
- Push onto a full FIFO:
  - With a pop in the same cycle, the push is accepted and the level stays the same.
  - Without a pop, the quad is dropped, overflow is set, and the pointers are unchanged.
- Push and pop in the same cycle otherwise: level unchanged, both pointers advance.
- Pointer wrap-around is modulo FIFO_DEPTH. The full/empty decision uses fillLevel, not pointer equality.
- frameStart handling:
  - The partial quad is discarded: the byte counter goes to 0 and the first-pending flag is set.
  - FIFO contents are untouched.
  - frameStart together with byteValid: that byte is byte 0 of the new frame, and the counter goes to 1.
  - frameStart together with the byte-7 completion: the old quad is discarded, not pushed.
- Overflow handling:
  - clearOverflow clears the flag.
  - clearOverflow together with a new drop leaves overflow=1 (set wins).
  - A dropped quad that carried the first flag leaves first-pending set, so the next pushed quad is marked first.
- Reset mid-frame: the partial quad and all FIFO contents are lost, and all outputs return to their reset values on the next edge.

Decomposition:
- Shared package rgb565_pkg holds:
  - PIXEL_W=16, BYTES_PER_PIXEL=2, PIXELS_PER_QUAD=4;
  - a quad typedef {first, b[31:0], a[31:0]};
  - byte-lane field positions shared with the grayscale instruction.
- One sub-module is natural: quad_sync_fifo, a single-clock synchronous FIFO of width 65 and depth FIFO_DEPTH.
  - It exposes push, pop, full, empty and level.
  - It has synchronous active-high reset and registered pointers.

Test Plan:
- Reset, then bytes F8 00 07 E0 00 1F FF FF (HIGH_BYTE_FIRST=1) -> 1 cycle after the last byte: quadValid=1, quadA=07E0F800, quadB=FFFF001F, quadFirst=1 (frameStart issued before the first byte).
- Second quad of the same frame with quadReady=1 -> the entry pops the same cycle quadValid is seen; second quad quadFirst=0; fillLevel returns to 0.
- quadReady=0, 5 quads streamed with FIFO_DEPTH=4:
  - fillLevel=4, then overflow=1 after the 5th quad;
  - the 4 stored quads pop out intact in order;
  - clearOverflow -> overflow=0.
- 5 bytes, then frameStart coinciding with byteValid=AA, then 7 more bytes:
  - exactly one quad results, pixel0 high byte=AA, quadFirst=1;
  - the discarded partial quad never appears.
- FIFO full with quadReady=1 on the same cycle byte 7 completes -> push accepted, fillLevel stays 4, overflow=0.
- reset asserted mid-quad with 2 entries stored -> next cycle quadValid=0, fillLevel=0; 8 fresh bytes yield a quad with quadFirst=1.
